// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: button, movement-handshake and status bundle
// between the elevator environment and the request scheduler.
interface elevator_scheduler_if;
   logic       button1;
   logic       button2;
   logic       button3;
   logic [1:0] floor;
   logic       arrived;
   logic       sos_mode;
   logic       weight_limit_exceeded;
   logic       led1;
   logic       led2;
   logic       led3;
   logic [1:0] goal_floor;
   logic       go;
   logic       door_open;
   logic       dir_up;
   logic       busy;

   modport master (
      output button1, button2, button3, floor, arrived,
      output sos_mode, weight_limit_exceeded,
      input  led1, led2, led3, goal_floor, go, door_open, dir_up, busy
   );

   modport slave (
      input  button1, button2, button3, floor, arrived,
      input  sos_mode, weight_limit_exceeded,
      output led1, led2, led3, goal_floor, go, door_open, dir_up, busy
   );
endinterface

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN request scheduler and door sequencer, 3 floors.
// Define SCHED_SOS_RECALL_EN to turn the sos freeze into a recall to floor 1.
module elevator_scheduler #(
   parameter logic [7:0] DOOR_TICKS = 8'd8
) (
   input logic                 clk,
   input logic                 button_reset_n,
   elevator_scheduler_if.slave bus
);
   localparam logic [1:0] labelF1 = 2'b00;
   localparam logic [1:0] labelF2 = 2'b01;
   localparam logic [1:0] labelF3 = 2'b10;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DISPATCH = 3'd1;
   localparam logic [2:0] TRAVEL   = 3'd2;
   localparam logic [2:0] DOOR     = 3'd3;
   localparam logic [2:0] HOLD     = 3'd4;

   logic [2:0] state;
   logic [2:0] req, btn_q, btn, rise;
   logic [2:0] here, above, below;
   logic [1:0] goal, up_goal, dn_goal, sel_goal;
   logic       go, door_open, dir_up;
   logic       new_dir, at_goal, far_end;
   logic [7:0] cnt;

   assign btn  = {bus.button3, bus.button2, bus.button1};
   assign rise = btn & ~btn_q;

   assign here = {bus.floor == labelF3,
                  bus.floor == labelF2,
                  bus.floor == labelF1};

   assign above = req & {bus.floor < labelF3,
                         bus.floor < labelF2, 1'b0};
   assign below = req & {1'b0, bus.floor > labelF2,
                         bus.floor > labelF1};

   assign up_goal  = above[1] ? labelF2 : labelF3;
   assign dn_goal  = below[1] ? labelF2 : labelF1;
   assign new_dir  = dir_up ? |above : ~|below;
   assign sel_goal = new_dir ? up_goal : dn_goal;

   assign at_goal = bus.arrived && bus.floor == goal;
   // still parked at one end while heading to the other
   assign far_end = (bus.floor == labelF1 && goal == labelF3) ||
                    (bus.floor == labelF3 && goal == labelF1);

   always_ff @(posedge clk or negedge button_reset_n) begin
      if (!button_reset_n) begin
         state     <= IDLE;
         req       <= '0;
         btn_q     <= '0;
         goal      <= labelF1;
         go        <= 1'b0;
         door_open <= 1'b0;
         dir_up    <= 1'b1;
         cnt       <= '0;
      end else begin
         btn_q <= btn;
         if (bus.sos_mode) begin
            if (state != HOLD) begin
               state <= HOLD;
`ifdef SCHED_SOS_RECALL_EN
               req       <= '0;
               goal      <= labelF1;
               go        <= bus.floor != labelF1;
               door_open <= bus.floor == labelF1;
`else
               go <= 1'b0;
`endif
            end
`ifdef SCHED_SOS_RECALL_EN
            else if (go && at_goal) begin
               go        <= 1'b0;
               door_open <= 1'b1;
            end
`endif
         end else begin
            unique case (state)
               IDLE: begin
                  req <= (req | rise) & ~here;
                  // a call at the standing floor just opens the door
                  if (|((rise | req) & here)) begin
                     door_open <= 1'b1;
                     cnt       <= DOOR_TICKS;
                     state     <= DOOR;
                  end else if (|req && !bus.weight_limit_exceeded) begin
                     dir_up <= new_dir;
                     goal   <= sel_goal;
                     state  <= DISPATCH;
                  end
               end
               DISPATCH: begin
                  req   <= req | rise;
                  go    <= 1'b1;
                  state <= TRAVEL;
               end
               TRAVEL: begin
                  if (at_goal) begin
                     req       <= (req | rise) & ~here;
                     go        <= 1'b0;
                     door_open <= 1'b1;
                     cnt       <= DOOR_TICKS;
                     state     <= DOOR;
                  end else begin
                     req <= req | rise;
                     if (rise[1] && !req[1] && far_end)
                        goal <= labelF2;
                  end
               end
               DOOR: begin
                  req <= req | (rise & ~here);
                  if (bus.weight_limit_exceeded || |(rise & here)) begin
                     cnt <= DOOR_TICKS;
                  end else if (cnt == 8'd1) begin
                     cnt       <= '0;
                     door_open <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               HOLD: begin
                  go <= 1'b0;
                  if (door_open) begin
                     cnt   <= DOOR_TICKS;
                     state <= DOOR;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.led1       = req[0];
   assign bus.led2       = req[1];
   assign bus.led3       = req[2];
   assign bus.goal_floor = goal;
   assign bus.go         = go;
   assign bus.door_open  = door_open;
   assign bus.dir_up     = dir_up;
   assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed vector table plus hand-written sequences
// for overload, re-press, SCAN turnaround, sos and asynchronous reset.
module tb_elevator_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   elevator_scheduler_if bus ();

   elevator_scheduler dut (
      .clk            (clk),
      .button_reset_n (rst_n),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] btn;
      logic [1:0] floor;
      logic       arr;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl [17];

   // {led3,led2,led1, goal[1:0], go, door_open, dir_up, busy}
   function automatic logic [8:0] outs();
      return {bus.led3, bus.led2, bus.led1, bus.goal_floor,
              bus.go, bus.door_open, bus.dir_up, bus.busy};
   endfunction

   function automatic logic [8:0] o(
      logic [2:0] l, logic [1:0] g, logic gv,
      logic d, logic up, logic bz);
      return {l, g, gv, d, up, bz};
   endfunction

   function automatic vec_t mk(
      logic [2:0] b, logic [1:0] f, logic a, logic [8:0] e);
      vec_t v;
      v.btn = b;
      v.floor = f;
      v.arr = a;
      v.exp = e;
      return v;
   endfunction

   task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(logic [2:0] b);
      {bus.button3, bus.button2, bus.button1} = b;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   localparam logic [8:0] RST = 9'b000_00_0_0_1_0;

   initial begin
      set_btn(3'b000);
      bus.floor = 2'b00;
      bus.arrived = 1'b0;
      bus.sos_mode = 1'b0;
      bus.weight_limit_exceeded = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("reset_state", outs(), RST);
      step();
      step();
      rst_n = 1'b1;

      tbl[0]  = mk(3'b100, 2'b00, 1'b0, o(3'b100, 2'b00, 0, 0, 1, 0));
      tbl[1]  = mk(3'b000, 2'b00, 1'b0, o(3'b100, 2'b10, 0, 0, 1, 1));
      tbl[2]  = mk(3'b000, 2'b00, 1'b0, o(3'b100, 2'b10, 1, 0, 1, 1));
      tbl[3]  = mk(3'b010, 2'b00, 1'b0, o(3'b110, 2'b01, 1, 0, 1, 1));
      tbl[4]  = mk(3'b000, 2'b01, 1'b0, o(3'b110, 2'b01, 1, 0, 1, 1));
      tbl[5]  = mk(3'b000, 2'b01, 1'b1, o(3'b100, 2'b01, 0, 1, 1, 1));
      for (int i = 6; i <= 12; i++)
         tbl[i] = mk(3'b000, 2'b01, 1'b0, o(3'b100, 2'b01, 0, 1, 1, 1));
      tbl[13] = mk(3'b000, 2'b01, 1'b0, o(3'b100, 2'b01, 0, 0, 1, 0));
      tbl[14] = mk(3'b000, 2'b01, 1'b0, o(3'b100, 2'b10, 0, 0, 1, 1));
      tbl[15] = mk(3'b000, 2'b01, 1'b0, o(3'b100, 2'b10, 1, 0, 1, 1));
      tbl[16] = mk(3'b000, 2'b10, 1'b1, o(3'b000, 2'b10, 0, 1, 1, 1));

      for (int i = 0; i < 17; i++) begin
         set_btn(tbl[i].btn);
         bus.floor = tbl[i].floor;
         bus.arrived = tbl[i].arr;
         step();
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end
      bus.arrived = 1'b0;

      // overload holds the door at F3, then a normal dwell
      bus.weight_limit_exceeded = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("wl_hold%0d", i), outs(),
             o(3'b000, 2'b10, 0, 1, 1, 1));
      end
      bus.weight_limit_exceeded = 1'b0;
      repeat (7) step();
      chk("wl_rel_open", outs(), o(3'b000, 2'b10, 0, 1, 1, 1));
      step();
      chk("wl_rel_close", outs(), o(3'b000, 2'b10, 0, 0, 1, 0));

      // call F2 from F3, then reset mid-DOOR with F1 pending
      set_btn(3'b010);
      step();
      chk("f2_led", outs(), o(3'b010, 2'b10, 0, 0, 1, 0));
      set_btn(3'b000);
      step();
      chk("f2_select", outs(), o(3'b010, 2'b01, 0, 0, 0, 1));
      step();
      chk("f2_go", outs(), o(3'b010, 2'b01, 1, 0, 0, 1));
      bus.floor = 2'b01;
      bus.arrived = 1'b1;
      step();
      bus.arrived = 1'b0;
      chk("f2_door", outs(), o(3'b000, 2'b01, 0, 1, 0, 1));
      set_btn(3'b001);
      step();
      set_btn(3'b000);
      chk("door_press", outs(), o(3'b001, 2'b01, 0, 1, 0, 1));
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_door", outs(), RST);
      rst_n = 1'b1;

      // press at the standing floor opens the door; re-press reloads dwell
      bus.floor = 2'b00;
      set_btn(3'b001);
      step();
      set_btn(3'b000);
      chk("idle_here", outs(), o(3'b000, 2'b00, 0, 1, 1, 1));
      repeat (3) step();
      set_btn(3'b001);
      step();
      set_btn(3'b000);
      repeat (7) step();
      chk("repress_open", outs(), o(3'b000, 2'b00, 0, 1, 1, 1));
      step();
      chk("repress_close", outs(), o(3'b000, 2'b00, 0, 0, 1, 0));

      // SCAN from F2 going up with F1 and F3 pending
      pulse_reset();
      bus.floor = 2'b01;
      set_btn(3'b101);
      step();
      set_btn(3'b000);
      chk("scan_led", outs(), o(3'b101, 2'b00, 0, 0, 1, 0));
      step();
      chk("scan_up", outs(), o(3'b101, 2'b10, 0, 0, 1, 1));
      step();
      bus.floor = 2'b10;
      bus.arrived = 1'b1;
      step();
      bus.arrived = 1'b0;
      chk("scan_f3", outs(), o(3'b001, 2'b10, 0, 1, 1, 1));
      repeat (8) step();
      chk("scan_close", outs(), o(3'b001, 2'b10, 0, 0, 1, 0));
      step();
      chk("scan_turn", outs(), o(3'b001, 2'b00, 0, 0, 0, 1));
      step();
      chk("scan_go", outs(), o(3'b001, 2'b00, 1, 0, 0, 1));
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_travel", outs(), RST);
      rst_n = 1'b1;

      // sos during TRAVEL F1 -> F3
      bus.floor = 2'b00;
      set_btn(3'b100);
      step();
      set_btn(3'b000);
      step();
      step();
      chk("sos_pre", outs(), o(3'b100, 2'b10, 1, 0, 1, 1));
      bus.floor = 2'b01;
      step();
      bus.sos_mode = 1'b1;
      step();
`ifdef SCHED_SOS_RECALL_EN
      chk("sos_enter", outs(), o(3'b000, 2'b00, 1, 0, 1, 1));
      set_btn(3'b010);
      step();
      set_btn(3'b000);
      chk("sos_press", outs(), o(3'b000, 2'b00, 1, 0, 1, 1));
      bus.floor = 2'b00;
      bus.arrived = 1'b1;
      step();
      bus.arrived = 1'b0;
      chk("sos_f1", outs(), o(3'b000, 2'b00, 0, 1, 1, 1));
      step();
      chk("sos_held", outs(), o(3'b000, 2'b00, 0, 1, 1, 1));
      bus.sos_mode = 1'b0;
      step();
      repeat (7) step();
      chk("sos_dwell", outs(), o(3'b000, 2'b00, 0, 1, 1, 1));
      step();
      chk("sos_close", outs(), o(3'b000, 2'b00, 0, 0, 1, 0));
`else
      chk("sos_enter", outs(), o(3'b100, 2'b10, 0, 0, 1, 1));
      set_btn(3'b010);
      step();
      set_btn(3'b000);
      chk("sos_press", outs(), o(3'b100, 2'b10, 0, 0, 1, 1));
      bus.sos_mode = 1'b0;
      step();
      chk("sos_exit", outs(), o(3'b100, 2'b10, 0, 0, 1, 0));
      step();
      chk("sos_select", outs(), o(3'b100, 2'b10, 0, 0, 1, 1));
      step();
      chk("sos_go", outs(), o(3'b100, 2'b10, 1, 0, 1, 1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
